// File: rtl/lut_seq_pkg.sv
// Shared types and width helpers for the folded LUT-layer sequencer.
package lut_seq_pkg;

  localparam int unsigned N_IN_DEF   = 32;
  localparam int unsigned N_OUT_DEF  = 32;
  localparam int unsigned FANIN_DEF  = 4;
  localparam int unsigned BW_IN_DEF  = 2;
  localparam int unsigned BW_OUT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Ceiling log2, never below 1 so derived fields always have a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table store: one write port, one registered read port.
module lut_table_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_q
);

  (* ram_style = "distributed" *) logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one LogicNets LUT layer: walks a shared
// truth-table RAM one neuron per cycle and collects the outputs.
module lut_layer_sequencer
  import lut_seq_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned N_OUT  = N_OUT_DEF,
  parameter int unsigned FANIN  = FANIN_DEF,
  parameter int unsigned BW_IN  = BW_IN_DEF,
  parameter int unsigned BW_OUT = BW_OUT_DEF,
  localparam int unsigned IW  = clog2(N_IN),
  localparam int unsigned NW  = clog2(N_OUT),
  localparam int unsigned SW  = clog2(FANIN),
  localparam int unsigned LW  = FANIN * BW_IN,
  localparam int unsigned TAW = NW + LW,
  // One spare bit above IW so out-of-range feature indices are representable.
  localparam int unsigned CDW = max2(BW_OUT, IW + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*BW_IN-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*BW_OUT-1:0] out_data,
  input  logic                    cfg_we,
  input  logic                    cfg_sel,
  input  logic [TAW-1:0]          cfg_addr,
  input  logic [CDW-1:0]          cfg_data,
  output logic                    cfg_err,
  output logic                    busy
);

  state_e              state_q, state_d;
  logic [NW-1:0]       idx_q, idx_d;
  logic [NW-1:0]       wb_idx_q, wb_idx_d;
  logic                wb_vld_q, wb_vld_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                cfg_err_q, cfg_err_d;
  logic [BW_IN-1:0]    x_q [N_IN];
  logic [BW_IN-1:0]    x_d [N_IN];
  logic [BW_OUT-1:0]   res_q [N_OUT];
  logic [BW_OUT-1:0]   res_d [N_OUT];
  logic [IW-1:0]       conn_q [N_OUT][FANIN];
  logic [IW-1:0]       conn_d [N_OUT][FANIN];

  logic [NW-1:0]       cfg_nrn_c;
  logic [SW-1:0]       cfg_slot_c;
  logic                cfg_bad_c;
  logic                tbl_we_c;
  logic                conn_we_c;
  logic [LW-1:0]       lut_idx_c;
  logic [BW_OUT-1:0]   rd_data;

  // Config decode: writes only land while idle and in range.
  always_comb begin
    cfg_nrn_c  = cfg_sel ? cfg_addr[SW +: NW] : cfg_addr[LW +: NW];
    cfg_slot_c = cfg_addr[SW-1:0];
    cfg_bad_c  = (state_q != IDLE)
              || ({1'b0, cfg_nrn_c} >= (NW+1)'(N_OUT))
              || (cfg_sel && (cfg_data >= CDW'(N_IN)));
    tbl_we_c   = cfg_we && !cfg_sel && !cfg_bad_c;
    conn_we_c  = cfg_we &&  cfg_sel && !cfg_bad_c;
  end

  always_comb begin
    conn_d = conn_q;
    if (conn_we_c) conn_d[cfg_nrn_c][cfg_slot_c] = cfg_data[IW-1:0];
  end

  always_ff @(posedge clk) begin
    conn_q <= conn_d;
  end

  // Gather this neuron's fan-in features; slot 0 lands in the LSBs.
  always_comb begin
    lut_idx_c = '0;
    for (int s = 0; s < FANIN; s++) begin
      lut_idx_c[s*BW_IN +: BW_IN] = x_q[conn_q[idx_q][SW'(s)]];
    end
  end

  lut_table_ram #(
    .AW (TAW),
    .DW (BW_OUT)
  ) u_table (
    .clk     (clk),
    .we      (tbl_we_c),
    .waddr   (cfg_addr),
    .wdata   (cfg_data[BW_OUT-1:0]),
    .raddr   ({idx_q, lut_idx_c}),
    .rdata_q (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    res_d       = res_q;
    wb_vld_d    = 1'b0;
    wb_idx_d    = idx_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = cfg_we && cfg_bad_c;

    // Table data arrives one cycle after its neuron was issued.
    if (wb_vld_q) res_d[wb_idx_q] = rd_data;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = RUN;
          idx_d   = '0;
          for (int f = 0; f < N_IN; f++) begin
            x_d[IW'(f)] = in_data[f*BW_IN +: BW_IN];
          end
        end
      end
      RUN: begin
        wb_vld_d = 1'b1;
        if (idx_q == NW'(N_OUT - 1)) state_d = FLUSH;
        else                         idx_d   = idx_q + NW'(1);
      end
      FLUSH: state_d = DONE;
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wb_idx_q    <= '0;
      wb_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      res_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wb_idx_q    <= wb_idx_d;
      wb_vld_q    <= wb_vld_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      res_q       <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
  end

  always_comb begin
    out_data = '0;
    for (int n = 0; n < N_OUT; n++) begin
      out_data[n*BW_OUT +: BW_OUT] = res_q[NW'(n)];
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Bench for lut_layer_sequencer: cycle-level reference model plus directed and random runs.
module tb_lut_layer_sequencer;

  localparam int unsigned N_IN = 4, N_OUT = 4, FANIN = 4, BW_IN = 2, BW_OUT = 2;
  localparam int unsigned TAW = 10, CDW = 3;

  logic                    clk = 1'b0;
  logic                    rst, in_valid, out_ready, cfg_we, cfg_sel;
  logic [N_IN*BW_IN-1:0]   in_data;
  logic [TAW-1:0]          cfg_addr;
  logic [CDW-1:0]          cfg_data;
  logic                    in_ready, out_valid, cfg_err, busy;
  logic [N_OUT*BW_OUT-1:0] out_data;

  lut_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .FANIN(FANIN), .BW_IN(BW_IN), .BW_OUT(BW_OUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tables, mapping, and a cycle count since the accept edge.
  int m_tbl  [N_OUT][256];
  int m_conn [N_OUT][FANIN];
  int m_x    [N_IN];
  int m_out  [N_OUT];
  bit m_busy, m_ov, m_err;
  int cnt;

  function automatic int eval(input int n);
    int lut;
    lut = 0;
    for (int s = 0; s < FANIN; s++) lut = lut | (m_x[m_conn[n][s]] << (2 * s));
    return m_tbl[n][lut];
  endfunction

  function automatic logic [7:0] m_pack();
    logic [7:0] r;
    for (int n = 0; n < N_OUT; n++) r[2*n +: 2] = 2'(m_out[n]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_ov = 0; m_err = 0; cnt = 0;
      for (int n = 0; n < N_OUT; n++) m_out[n] = 0;
    end else begin
      int a, nrn;
      m_err = 0;
      if (cfg_we) begin
        a   = int'(cfg_addr);
        nrn = cfg_sel ? ((a >> 2) & 3) : (a >> 8);
        if (m_busy || nrn >= N_OUT || (cfg_sel && int'(cfg_data) >= N_IN)) m_err = 1;
        else if (cfg_sel) m_conn[nrn][a & 3] = int'(cfg_data);
        else              m_tbl[nrn][a & 255] = int'(cfg_data) & 3;
      end
      if (m_busy) begin
        if (m_ov && out_ready) begin
          m_busy = 0; m_ov = 0;
        end else begin
          cnt++;
          if (cnt >= 2 && cnt <= N_OUT + 1) m_out[cnt-2] = eval(cnt - 2);
          if (cnt == N_OUT + 2) m_ov = 1;
        end
      end else if (in_valid) begin
        for (int f = 0; f < N_IN; f++) m_x[f] = int'(in_data[2*f +: 2]);
        m_busy = 1; cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_data",  32'(out_data),  32'(m_pack()));
      check("model_out_valid", 32'(out_valid), 32'(m_ov));
      check("model_in_ready",  32'(in_ready),  32'(!m_busy));
      check("model_busy",      32'(busy),      32'(m_busy));
      check("model_cfg_err",   32'(cfg_err),   32'(m_err));
    end
  end

  task automatic cfg_wr(input bit sel, input int addr, input int data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = TAW'(addr); cfg_data = CDW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start(input logic [7:0] x);
    in_valid = 1'b1; in_data = x;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid !== 1'b1) check("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_run(input int stall);
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [7:0] x, input int stall, output logic [7:0] res);
    int lat;
    start(x);
    wait_valid(lat);
    check("latency", 32'(lat), 32'd6);
    res = out_data;
    finish_run(stall);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] res;
    int lat;
    rst = 1; in_valid = 0; out_ready = 0; cfg_we = 0; cfg_sel = 0;
    cfg_addr = '0; cfg_data = '0; in_data = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);

    // Identity mapping, neuron n passes through slot n
    for (int n = 0; n < 4; n++)
      for (int s = 0; s < 4; s++) cfg_wr(1'b1, n*4 + s, s);
    for (int n = 0; n < 4; n++)
      for (int l = 0; l < 256; l++) cfg_wr(1'b0, n*256 + l, (l >> (2*n)) & 3);
    run(8'hE4, 0, res);
    check("t2_result", 32'(res), 32'hE4);

    // Backpressure holds the result
    start(8'hE4);
    wait_valid(lat);
    check("t3_latency", 32'(lat), 32'd6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_data", 32'(out_data), 32'hE4);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
      check("t3_hold_busy", 32'(busy), 32'd1);
    end
    finish_run(0);
    check("t3_idle_in_ready", 32'(in_ready), 32'd1);
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_idle_valid", 32'(out_valid), 32'd0);
    check("t3_data_kept", 32'(out_data), 32'hE4);

    // Config while busy is rejected
    start(8'hE4);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = 3'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    check("t4_busy_err", 32'(cfg_err), 32'd1);
    @(negedge clk);
    check("t4_err_pulse", 32'(cfg_err), 32'd0);
    wait_valid(lat);
    check("t4_during", 32'(out_data), 32'hE4);
    finish_run(0);
    run(8'hE4, 1, res);
    check("t4_rerun", 32'(res), 32'hE4);
    cfg_wr(1'b1, 0, 4);
    check("t4_range_err", 32'(cfg_err), 32'd1);
    run(8'hE4, 0, res);
    check("t4_map_kept", 32'(res), 32'hE4);

    // Reset mid-run
    start(8'hE4);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_data", 32'(out_data), 32'd0);
    run(8'hE4, 0, res);
    check("t5_fresh", 32'(res), 32'hE4);

    // Config and sample in the same idle cycle
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = 3'd3;
    in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_valid(lat);
    check("t6_latency", 32'(lat), 32'd6);
    res = out_data;
    check("t6_n0", 32'(res[1:0]), 32'd3);
    check("t6_all", 32'(res), 32'h03);
    finish_run(0);

    // Random mapping, tables and traffic
    for (int n = 0; n < 4; n++)
      for (int s = 0; s < 4; s++) cfg_wr(1'b1, n*4 + s, int'($urandom_range(0, 3)));
    for (int a = 0; a < 1024; a++) cfg_wr(1'b0, a, int'($urandom_range(0, 7)));
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 2) == 0) cfg_wr(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) begin
        cfg_we = 1'b1; cfg_sel = $urandom_range(0, 1) == 1;
        cfg_addr = TAW'($urandom); cfg_data = CDW'($urandom);
      end
      start(8'($urandom));
      cfg_we = 1'b0;
      for (int c = 0; c < 3; c++) begin
        cfg_we = $urandom_range(0, 1) == 1; cfg_sel = $urandom_range(0, 1) == 1;
        cfg_addr = TAW'($urandom); cfg_data = CDW'($urandom);
        @(negedge clk);
        cfg_we = 1'b0;
      end
      wait_valid(lat);
      finish_run(int'($urandom_range(0, 3)));
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
